// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one multi-cycle 8-bit ALU between NUM_REQ requesters
module alu_share_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ALU_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_opcode,
    input  logic [8*NUM_REQ-1:0]   req_operand1,
    input  logic [8*NUM_REQ-1:0]   req_operand2,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [7:0]             resp_result,
    output logic                   resp_err,
    output logic                   busy,
    output logic [1:0]             alu_opcode,
    output logic [7:0]             alu_operand1,
    output logic [7:0]             alu_operand2,
    input  logic [7:0]             alu_result
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       ptr, owner, win;
    logic                found;
    logic [NUM_REQ-1:0]  rot;
    logic [1:0]          win_op;
    logic [7:0]          win_a, win_b;
    logic                div_zero;
    logic                own_ready;
    logic [3:0]          cnt;

    // rotate the request vector so bit 0 is the requester just after the last winner
    always_comb begin
        rot = NUM_REQ'({req_valid, req_valid} >> (int'(ptr) + 1));
    end

    // lowest set bit of the rotated vector is the round-robin winner
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                win   = PW'((int'(ptr) + j + 1) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    // select the winner's opcode and operands
    always_comb begin
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PW'(i)) begin
                win_op = req_opcode[2*i +: 2];
                win_a  = req_operand1[8*i +: 8];
                win_b  = req_operand2[8*i +: 8];
            end
        end
        div_zero = (win_op == 2'b11) && (win_b == 8'd0);
    end

    // handshake strobes; both channels are held off while reset is asserted
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        own_ready  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i]  = reset_n && (state == IDLE) && found && (win == PW'(i));
            resp_valid[i] = reset_n && (state == RESP) && (owner == PW'(i));
            own_ready     = own_ready | (resp_ready[i] && (owner == PW'(i)));
        end
        busy = (state != IDLE);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next state: divide-by-zero skips the ALU entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = found ? (div_zero ? RESP : EXEC) : IDLE;
            EXEC:    state_nxt = (cnt == 4'd0) ? RESP : EXEC;
            RESP:    state_nxt = own_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // pointer and owner move only when a request is accepted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr   <= PW'(NUM_REQ - 1);
            owner <= '0;
        end else if (state == IDLE && found) begin
            ptr   <= win;
            owner <= win;
        end
    end

    // ALU operand registers, held for the whole operation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alu_opcode   <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
        end else if (state == IDLE && found) begin
            alu_opcode   <= win_op;
            alu_operand1 <= win_a;
            alu_operand2 <= win_b;
        end
    end

    // latency counter; the result is sampled one edge after it has been valid for a full cycle
    always_ff @(posedge clk) begin
        if (!reset_n)                      cnt <= '0;
        else if (state == IDLE && found)   cnt <= 4'(ALU_LATENCY);
        else if (state == EXEC && cnt != 0) cnt <= cnt - 4'd1;
    end

    // response registers, held stable through RESP
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_result <= '0;
            resp_err    <= 1'b0;
        end else if (state == IDLE && found && div_zero) begin
            resp_result <= 8'hFF;
            resp_err    <= 1'b1;
        end else if (state == EXEC && cnt == 4'd0) begin
            resp_result <= alu_result;
            resp_err    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: random and directed traffic checked against a transaction-level model
module tb_alu_share_arbiter;

    localparam int NR = 3;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [NR-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [2*NR-1:0] req_opcode;
    logic [8*NR-1:0] req_operand1, req_operand2;
    logic [7:0]      resp_result, alu_operand1, alu_operand2, alu_result;
    logic [1:0]      alu_opcode;
    logic            resp_err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] opc [NR];
    logic [7:0] a   [NR];
    logic [7:0] b   [NR];
    logic [7:0] pipe [L];

    bit         m_busy;
    int         m_owner, m_ptr, m_wait;
    logic [1:0] m_op;
    logic [7:0] m_a1, m_a2, m_res;
    logic       m_err;
    int         regen = -1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(NR), .ALU_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_operand1(req_operand1), .req_operand2(req_operand2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_err(resp_err), .busy(busy),
        .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result)
    );

    always_comb begin
        req_opcode   = '0;
        req_operand1 = '0;
        req_operand2 = '0;
        for (int i = 0; i < NR; i++) begin
            req_opcode[2*i +: 2]   = opc[i];
            req_operand1[8*i +: 8] = a[i];
            req_operand2[8*i +: 8] = b[i];
        end
    end

    function automatic logic [7:0] alu_f(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'b00:   return x + y;
            2'b01:   return x - y;
            2'b10:   return x * y;
            default: return (y == 8'd0) ? 8'd0 : x / y;
        endcase
    endfunction

    // shared ALU: result appears L edges after operands
    always @(posedge clk) begin
        pipe[0] <= alu_f(alu_opcode, alu_operand1, alu_operand2);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_result = pipe[L-1];

    function automatic logic [8:0] ref_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int r;
        if (o == 2'b11 && y == 8'd0) return {1'b1, 8'hFF};
        case (o)
            2'b00:   r = (int'(x) + int'(y)) % 256;
            2'b01:   r = (int'(x) - int'(y) + 256) % 256;
            2'b10:   r = (int'(x) * int'(y)) % 256;
            default: r = int'(x) / int'(y);
        endcase
        return {1'b0, 8'(r)};
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int i = p + 1; i < NR; i++) if (v[i]) return i;
        for (int i = 0; i <= p; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic new_op(input int i);
        opc[i] = 2'($urandom_range(0, 3));
        a[i]   = 8'($urandom);
        b[i]   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
    endtask

    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] rr);
        int w;
        logic [NR-1:0] ev;
        logic [8:0] r;
        @(negedge clk);
        req_valid  = v;
        resp_ready = rr;
        #1;
        w  = m_busy ? -1 : pick(v, m_ptr);
        ev = (m_busy && m_wait == 0) ? NR'(1 << m_owner) : '0;
        chk("req_ready", 32'(req_ready), (w < 0) ? 0 : (1 << w));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (ev != 0) begin
            chk("resp_result", 32'(resp_result), 32'(m_res));
            chk("resp_err", 32'(resp_err), 32'(m_err));
        end
        if (m_busy) chk("alu_bus", 32'({alu_opcode, alu_operand1, alu_operand2}), 32'({m_op, m_a1, m_a2}));
        if (w >= 0) begin
            m_busy  = 1;
            m_owner = w;
            m_ptr   = w;
            m_op    = opc[w];
            m_a1    = a[w];
            m_a2    = b[w];
            r       = ref_op(opc[w], a[w], b[w]);
            m_err   = r[8];
            m_res   = r[7:0];
            m_wait  = m_err ? 0 : L + 1;
            regen   = w;
        end else if (m_busy) begin
            if (m_wait > 0) m_wait--;
            else if (rr[m_owner]) m_busy = 0;
        end
        @(posedge clk);
        #1;
        if (regen >= 0) new_op(regen);
        regen = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        req_valid  = '1;
        resp_ready = '1;
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result", 32'({resp_err, resp_result}), 0);
        chk("rst_alu", 32'({alu_opcode, alu_operand1, alu_operand2}), 0);
        reset_n   = 1'b1;
        req_valid = '0;
        m_busy    = 0;
        m_ptr     = NR - 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NR; i++) new_op(i);
        req_valid  = '0;
        resp_ready = '0;
        m_busy     = 0;
        m_ptr      = NR - 1;
        do_reset();
        opc[0] = 2'b00; a[0] = 8'd200; b[0] = 8'd100;
        repeat (6) step(3'b001, '1);
        do_reset();
        repeat (30) step(3'b011, '1);
        repeat (8) step('0, '1);
        opc[1] = 2'b11; a[1] = 8'd9; b[1] = 8'd0;
        repeat (4) step(3'b010, '1);
        repeat (4) step('0, '1);
        opc[2] = 2'b10; a[2] = 8'd16; b[2] = 8'd17;
        repeat (6) step(3'b100, '1);
        repeat (4) step('0, '1);
        opc[0] = 2'b01; a[0] = 8'd3; b[0] = 8'd5;
        repeat (6) step(3'b001, '1);
        repeat (4) step('1, '1);
        repeat (8) step('1, '0);
        repeat (4) step('1, '1);
        repeat (12) step('0, '1);
        opc[1] = 2'b00; opc[2] = 2'b00;
        step(3'b110, '1);
        step('0, '0);
        do_reset();
        step(3'b111, '1);
        repeat (2000) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(NR'($urandom), ($urandom_range(0, 2) == 0) ? NR'($urandom) : '1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
